// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and shared types for the scan controller.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Free-running clock divider: one-clk pix_tick every CLK_DIV clks.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  generate
    if (CLK_DIV <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign pix_tick  = 1'b1;
    end else begin : g_div
      localparam int            DW   = $clog2(CLK_DIV);
      localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_q, div_d;

      always_comb div_d = (div_q == LAST) ? '0 : div_q + 1'b1;

      always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
      end

      assign pix_tick = (div_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: pixel/line counters, frame-granular run control and an
// output register that aligns datapath colour with the syncs for the DAC.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [9:0] hc,
  output logic [8:0] vc,
  output logic       display_enable,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  scan_state_t state_q, state_d;
  logic [9:0]  hc_q, hc_d, line_q, line_d;
  rgb_t        pix_q, pix_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        scanning, h_end, frame_end, hs_act, vs_act;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  assign scanning  = (state_q != IDLE);
  assign h_end     = (hc_q == H_LAST);
  assign frame_end = h_end && (line_q == V_LAST);
  assign hs_act    = scanning && (hc_q >= H_SS) && (hc_q < H_SE);
  assign vs_act    = scanning && (line_q >= V_SS) && (line_q < V_SE);

  assign hc             = hc_q;
  assign vc             = (line_q < V_VIS) ? line_q[8:0] : 9'd0;
  assign display_enable = scanning && (hc_q < H_VIS) && (line_q < V_VIS);
  assign line_start     = pix_tick && scanning && (hc_q == '0);
  assign frame_start    = line_start && (line_q == '0);

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    line_d  = line_q;
    pix_d   = pix_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (pix_tick) begin
      // Colour gated here so blanking is black whatever the generators drive.
      pix_d.r = display_enable ? r_in : 8'h00;
      pix_d.g = display_enable ? g_in : 8'h00;
      pix_d.b = display_enable ? b_in : 8'h00;
      hs_d    = hs_act ? SYNC_POL : ~SYNC_POL;
      vs_d    = vs_act ? SYNC_POL : ~SYNC_POL;
      if (state_q == IDLE) begin
        hc_d   = '0;
        line_d = '0;
        if (run) state_d = RUN;
      end else begin
        hc_d = h_end ? '0 : hc_q + 1'b1;
        if (h_end) line_d = (line_q == V_LAST) ? '0 : line_q + 1'b1;
        case (state_q)
          RUN:     if (!run) state_d = frame_end ? IDLE : DRAIN;
          DRAIN:   if (run) state_d = RUN;
                   else if (frame_end) state_d = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      line_q  <= '0;
      pix_q.r <= '0;
      pix_q.g <= '0;
      pix_q.b <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign vga_r  = pix_q.r;
  assign vga_g  = pix_q.g;
  assign vga_b  = pix_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule
